seq_divider: RTL
================

# seq_divider

Parametrised multi-cycle restoring divider, successor to the fixed-width shift/subtract division datapath. It owns its own control: a start/done handshake, an internal FSM and bit counter, and divide-by-zero detection. The subtractor is internal, so no external adder or mux is needed. It sits beside the multiplier in the arithmetic unit and produces one quotient bit per clock.

## Interface
- `DW`, default 8: operand, quotient and remainder width; legal range is 2 or more.
- `clk` in, 1 bit: clock; all state changes on the rising edge.
- `reset` in, 1 bit: asynchronous, active-high reset.
- `start` in, 1 bit: request a division; sampled only in IDLE.
- `dividend` in, DW bits: numerator; captured on the accepting edge.
- `divisor` in, DW bits: denominator; captured on the accepting edge.
- `signed_op` in, 1 bit: present only when `SEQ_DIVIDER_SIGNED_EN` is defined; selects two's-complement operation; captured with the operands.
- `busy` out, 1 bit: high in the RUN and DONE states.
- `done` out, 1 bit: one-cycle pulse in the DONE state.
- `quotient` out, DW bits: result; held from DONE until the next accepted start.
- `remainder` out, DW bits: result; held from DONE until the next accepted start.
- `div_by_zero` out, 1 bit: flag for the last operation; same hold rule as the results.

## Operation
- The FSM has three states: IDLE, RUN and DONE. Reset places it in IDLE.
- **IDLE, start=1, divisor≠0:**
  - Latch the operand magnitudes.
  - Clear the partial remainder, which is DW+1 bits wide.
  - Load the bit counter with DW-1.
  - Move to RUN.
- **IDLE, start=1, divisor=0:**
  - Move directly to DONE.
  - Set quotient to all ones, remainder to the dividend, and div_by_zero to 1.
- **RUN, every cycle:**
  - Shift {partial remainder, dividend register} left by 1.
  - Trial-subtract the divisor from the upper DW+1 bits.
  - If the result is non-negative, keep the difference and shift in quotient bit 1.
  - Otherwise restore the value and shift in quotient bit 0.
  - Decrement the counter. When the counter reaches 0, register the final results (sign fix-up included) and move to DONE.
- **DONE:**
  - Assert `done` for exactly one cycle, then return to IDLE.
  - Results and div_by_zero stay stable until the next accepted start.
- **Start handling:**
  - `start` in RUN or DONE is ignored; it is not queued.
  - `start` held high through DONE is accepted on the first IDLE edge.
- **Arithmetic:**
  - Unsigned: quotient = floor(dividend/divisor) and remainder = dividend − quotient·divisor, both exact within DW bits.
- **Reset mid-operation:** any in-flight division is abandoned and the block returns to IDLE with all outputs at 0.

## Timing
- Reset values:
  - busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, state IDLE.
- Latency, counted from the rising edge that samples start=1 in IDLE (edge 0):
  - Nonzero divisor: RUN spans edges 1..DW, and done is high in the cycle after edge DW, i.e. DW+1 cycles after acceptance.
  - Zero divisor: done is high in the cycle after edge 0.
- `busy` rises in the cycle after the accepting edge and falls together with `done`.
- Throughput:
  - Back-to-back starts give one result every DW+2 cycles.
  - Back-to-back zero-divisor operations give one result every 2 cycles.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- Signed support is controlled by the macro `SEQ_DIVIDER_SIGNED_EN`.
- **Macro defined:**
  - The `signed_op` port exists.
  - When signed_op=1, the block divides operand magnitudes.
  - The quotient is negated if the operand signs differ, and the remainder takes the dividend's sign. The fix-up is applied while registering the results, so latency is unchanged.
  - MIN/−1 gives quotient=MIN (wraps) and remainder=0, with no flag raised.
  - Divide by zero in signed mode gives quotient all ones and remainder = dividend.
- **Macro undefined:**
  - The `signed_op` port is absent.
  - All operation is unsigned.
  - No sign logic is synthesised.

## Test plan
- **Unsigned divide:** DW=8, 100/7 → quotient=14, remainder=2, div_by_zero=0; done pulses exactly 9 cycles after the accepting edge; busy is high for 9 cycles.
- **Divide by one:** 255/1 → quotient=255, remainder=0; then 3/200 → quotient=0, remainder=3.
- **Divide by zero:** 13/0 → quotient=0xFF, remainder=13, div_by_zero=1; done pulses 1 cycle after acceptance; the next 13/5 clears the flag and gives quotient=2, remainder=3.
- **Start while busy:** start 100/7, then pulse start with 50/5 on RUN cycle 3 → only 14 r2 is produced and a single done pulse occurs.
- **Reset mid-run:** assert reset on RUN cycle 4 → all outputs read 0 immediately; after release, 9/3 → quotient=3, remainder=0.
- **Signed mode** (`SEQ_DIVIDER_SIGNED_EN` defined, signed_op=1):
  - −7/2 → quotient=0xFD, remainder=0xFF.
  - 7/−2 → quotient=0xFD, remainder=0x01.
  - −128/−1 → quotient=0x80, remainder=0.

Source files
------------

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
//
// Multi-cycle restoring divider. A division starts from IDLE and then produces
// one quotient bit per clock. The controller, bit counter, subtractor and
// divide-by-zero detection are all inside this block.
//
// Parameters:
//   DW          operand, quotient and remainder width (2 or more)
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous, active-high reset
//   start       division request; it is only looked at in IDLE
//   dividend    numerator, captured on the accepting edge
//   divisor     denominator, captured on the accepting edge
//   signed_op   two's-complement select (SEQ_DIVIDER_SIGNED_EN builds only)
//   busy        high while in RUN or DONE
//   done        one-cycle pulse in DONE
//   quotient    result, held from DONE until the next accepted start
//   remainder   result, held from DONE until the next accepted start
//   div_by_zero divisor was zero for the last operation (same hold rule)
//
// Build option:
//   SEQ_DIVIDER_SIGNED_EN  adds signed_op and the sign fix-up logic
//
// Handshake: start is sampled on a rising edge only while the FSM is in IDLE.
// The edge that samples it is the accepting edge. Requests made in RUN or DONE
// are dropped and are not queued. done is high for exactly one cycle. If start
// stays high through DONE, it is accepted on the first edge back in IDLE.
//
// The FSM state is held in state_q (type state_e) so checkers can observe it.
// -----------------------------------------------------------------------------
module seq_divider #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [DW-1:0] divisor,
`ifdef SEQ_DIVIDER_SIGNED_EN
    input  logic          signed_op,
`endif
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [DW-1:0] remainder,
    output logic          div_by_zero
);

    localparam int CW = $clog2(DW);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [DW:0]   rem_q, rem_d;      // partial remainder, DW+1 bits
    logic [DW-1:0] dvd_q, dvd_d;      // dividend shifts out, quotient shifts in
    logic [DW-1:0] dvs_q, dvs_d;      // divisor magnitude
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] quo_q, quo_d;
    logic [DW-1:0] rmd_q, rmd_d;
    logic          dbz_q, dbz_d;

    logic [DW+1:0] shifted;
    logic [DW+1:0] diff;
    logic          step_ok;
    logic [DW:0]   rem_next;
    logic [DW-1:0] dvd_next;
    logic [DW-1:0] dvd_mag, dvs_mag;
    logic [DW-1:0] quo_fix, rmd_fix;

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic neg_quo_q, neg_quo_d;
    logic neg_rem_q, neg_rem_d;
    logic dvd_neg, dvs_neg;
`endif

    // One restoring step. shifted is one bit wider than the partial remainder.
    // Its MSB is always 0, but it lets the sign of the trial difference be read
    // directly as the borrow.
    always_comb begin
        shifted  = {rem_q, dvd_q[DW-1]};
        diff     = shifted - {2'b00, dvs_q};
        step_ok  = ~diff[DW+1];
        rem_next = step_ok ? diff[DW:0] : shifted[DW:0];
        dvd_next = {dvd_q[DW-2:0], step_ok};
    end

`ifdef SEQ_DIVIDER_SIGNED_EN
    // The core always divides magnitudes. Taking the magnitude of MIN gives
    // MIN again, which is the correct unsigned value. The signs are restored
    // while the results are registered.
    always_comb begin
        dvd_neg = signed_op & dividend[DW-1];
        dvs_neg = signed_op & divisor[DW-1];
        dvd_mag = dvd_neg ? (~dividend + 1'b1) : dividend;
        dvs_mag = dvs_neg ? (~divisor + 1'b1) : divisor;
        quo_fix = neg_quo_q ? (~dvd_next + 1'b1) : dvd_next;
        rmd_fix = neg_rem_q ? (~rem_next[DW-1:0] + 1'b1) : rem_next[DW-1:0];
    end
`else
    always_comb begin
        dvd_mag = dividend;
        dvs_mag = divisor;
        quo_fix = dvd_next;
        rmd_fix = rem_next[DW-1:0];
    end
`endif

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        dbz_d   = dbz_q;
`ifdef SEQ_DIVIDER_SIGNED_EN
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (divisor == '0) begin
                        // No iterations are needed, so the result is ready at once.
                        quo_d   = '1;
                        rmd_d   = dividend;
                        dbz_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        dvd_d   = dvd_mag;
                        dvs_d   = dvs_mag;
                        rem_d   = '0;
                        cnt_d   = CW'(DW - 1);
`ifdef SEQ_DIVIDER_SIGNED_EN
                        neg_quo_d = dvd_neg ^ dvs_neg;
                        neg_rem_d = dvd_neg;
`endif
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                rem_d = rem_next;
                dvd_d = dvd_next;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    quo_d   = quo_fix;
                    rmd_d   = rmd_fix;
                    dbz_d   = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rmd_q   <= '0;
            dbz_q   <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            dbz_q   <= dbz_d;
`ifdef SEQ_DIVIDER_SIGNED_EN
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
`endif
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign quotient    = quo_q;
    assign remainder   = rmd_q;
    assign div_by_zero = dbz_q;

endmodule
